prbs4_checker: RTL and testbench

PRBS4_CHECKER -- requirements
Module: prbs4_checker

---
 rtl/prbs4_pkg.sv | 34 +++
 rtl/sat_counter8.sv | 46 ++++
 rtl/prbs4_checker.sv | 178 +++++++++++++++++
 tb/tb_prbs4_checker.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs4_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prbs4_pkg
// Description : Shared definitions for the PRBS-4 checker: FSM state type,
//               register width, feedback taps, XNOR feedback function and the
//               lock-up (all-ones) register value.
// Revision    : 1.0 - initial release
// ============================================================================
package prbs4_pkg;

    localparam int PRBS_WIDTH = 4;

    // Feedback taps for x^4 + x^3 + 1
    localparam int TAP_HI = 3;
    localparam int TAP_LO = 2;

    // With XNOR feedback the all-ones register maps onto itself, so the
    // generator can never leave it.
    localparam logic [PRBS_WIDTH-1:0] LOCKUP_STATE = 4'b1111;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2,
        ST_RSVD   = 2'd3
    } state_e;

    // Next bit the generator emits from the current register contents.
    function automatic logic prbs_predict(input logic [PRBS_WIDTH-1:0] s);
        return ~(s[TAP_HI] ^ s[TAP_LO]);
    endfunction

endpackage : prbs4_pkg
`default_nettype wire

// File: rtl/sat_counter8.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter8
// Description : 8-bit up counter with synchronous clear and saturation at 255.
//               Clear has priority over increment.
// Ports       : clk      - clock, rising edge
//               reset    - asynchronous active-high reset
//               clear_i  - synchronous clear to zero
//               inc_i    - increment request
//               count_o  - current count value
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       inc_i,
    output logic [7:0] count_o
);

    localparam logic [7:0] c_max = 8'hFF;

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (inc_i && (count_q != c_max)) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : sat_counter8
`default_nettype wire

// File: rtl/prbs4_checker.sv
`default_nettype none
// ============================================================================
// Module      : prbs4_checker
// Description : Serial PRBS-4 (x^4+x^3+1, XNOR feedback) checker. Seeds a
//               local predictor from the received stream, verifies a run of
//               matching bits, then tracks the sequence free-running and
//               counts bit errors while locked.
// Ports       : clk            - clock, rising edge
//               reset          - asynchronous active-high reset
//               enable_i       - data_in_i is valid this cycle
//               data_in_i      - received serial bit
//               clear_count_i  - synchronous clear of err_count_o
//               locked_o       - high while in LOCKED
//               err_pulse_o    - one-cycle pulse after each locked mismatch
//               err_count_o    - saturating count of locked mismatches
//               state_o        - current FSM state code (debug)
// Parameters  : LOCK_THRESH    - consecutive matches needed to lock (1..15)
//               LOSS_THRESH    - consecutive locked mismatches to drop (1..7)
// Revision    : 1.0 - initial release
// ============================================================================
module prbs4_checker
    import prbs4_pkg::*;
#(
    parameter int LOCK_THRESH = 8,
    parameter int LOSS_THRESH = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable_i,
    input  logic       data_in_i,
    input  logic       clear_count_i,
    output logic       locked_o,
    output logic       err_pulse_o,
    output logic [7:0] err_count_o,
    output logic [1:0] state_o
);

    localparam logic [3:0] c_lock_thresh = 4'(LOCK_THRESH);
    localparam logic [2:0] c_loss_thresh = 3'(LOSS_THRESH);

    state_e                  state_q,     state_d;
    logic [PRBS_WIDTH-1:0]   shreg_q,     shreg_d;
    logic [1:0]              seed_cnt_q,  seed_cnt_d;
    logic [3:0]              match_cnt_q, match_cnt_d;
    logic [2:0]              loss_cnt_q,  loss_cnt_d;
    logic                    err_pulse_q, err_pulse_d;

    logic                    w_pred;
    logic                    w_mismatch;
    logic [PRBS_WIDTH-1:0]   w_shift_in;
    logic [3:0]              w_match_inc;
    logic [2:0]              w_loss_inc;
    logic                    w_err_inc;

    assign w_pred      = prbs_predict(shreg_q);
    assign w_mismatch  = (data_in_i != w_pred);
    assign w_shift_in  = {shreg_q[PRBS_WIDTH-2:0], data_in_i};
    assign w_match_inc = match_cnt_q + 4'd1;
    assign w_loss_inc  = loss_cnt_q + 3'd1;

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        seed_cnt_d  = seed_cnt_q;
        match_cnt_d = match_cnt_q;
        loss_cnt_d  = loss_cnt_q;
        err_pulse_d = 1'b0;
        w_err_inc   = 1'b0;

        case (state_q)
            ST_SEED: begin
                if (enable_i) begin
                    shreg_d = w_shift_in;
                    if (seed_cnt_q == 2'd3) begin
                        seed_cnt_d = 2'd0;
                        // An all-ones seed would predict all-ones forever;
                        // discard it and take a fresh window of four bits.
                        if (w_shift_in != LOCKUP_STATE) begin
                            state_d     = ST_VERIFY;
                            match_cnt_d = 4'd0;
                        end
                    end else begin
                        seed_cnt_d = seed_cnt_q + 2'd1;
                    end
                end
            end

            ST_VERIFY: begin
                if (enable_i) begin
                    shreg_d = w_shift_in;
                    if (!w_mismatch) begin
                        if (w_match_inc == c_lock_thresh) begin
                            state_d     = ST_LOCKED;
                            match_cnt_d = 4'd0;
                            loss_cnt_d  = 3'd0;
                        end else begin
                            match_cnt_d = w_match_inc;
                        end
                    end else begin
                        state_d     = ST_SEED;
                        match_cnt_d = 4'd0;
                        seed_cnt_d  = 2'd0;
                    end
                end
            end

            ST_LOCKED: begin
                if (enable_i) begin
                    // Advance on the predicted bit so an isolated received
                    // error does not corrupt the local sequence.
                    shreg_d = {shreg_q[PRBS_WIDTH-2:0], w_pred};
                    if (w_mismatch) begin
                        err_pulse_d = 1'b1;
                        w_err_inc   = 1'b1;
                        if (w_loss_inc == c_loss_thresh) begin
                            state_d    = ST_SEED;
                            loss_cnt_d = 3'd0;
                            seed_cnt_d = 2'd0;
                        end else begin
                            loss_cnt_d = w_loss_inc;
                        end
                    end else begin
                        loss_cnt_d = 3'd0;
                    end
                end
            end

            default: begin
                // Unused code: recover unconditionally with clean counters.
                state_d     = ST_SEED;
                seed_cnt_d  = 2'd0;
                match_cnt_d = 4'd0;
                loss_cnt_d  = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SEED;
            shreg_q     <= '0;
            seed_cnt_q  <= 2'd0;
            match_cnt_q <= 4'd0;
            loss_cnt_q  <= 3'd0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            seed_cnt_q  <= seed_cnt_d;
            match_cnt_q <= match_cnt_d;
            loss_cnt_q  <= loss_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    // ------------------------------------------------------------------------
    // Error counter
    // ------------------------------------------------------------------------
    sat_counter8 u_err_counter (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear_count_i),
        .inc_i   (w_err_inc),
        .count_o (err_count_o)
    );

    assign locked_o    = (state_q == ST_LOCKED);
    assign err_pulse_o = err_pulse_q;
    assign state_o     = state_q;

endmodule : prbs4_checker
`default_nettype wire

// File: tb/tb_prbs4_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_prbs4_checker
// Description : Self-checking bench for prbs4_checker. A table-driven model
//               locates the received seed window inside the 15-bit reference
//               sequence and predicts later bits by table position.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prbs4_checker;

    localparam int LOCK_T = 8;
    localparam int LOSS_T = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       data_in;
    logic       clear_count;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic [1:0] state;

    int ref_bits [15] = '{1,1,1,0,1,1,0,0,1,0,1,0,0,0,0};

    int total = 0;
    int bad   = 0;
    int g     = 0;   // generator position of the next transmitted bit

    // Reference model
    int m_state, m_win, m_n, m_match, m_loss, m_pos, m_pulse, m_cnt;

    prbs4_checker #(
        .LOCK_THRESH (LOCK_T),
        .LOSS_THRESH (LOSS_T)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable_i      (enable),
        .data_in_i     (data_in),
        .clear_count_i (clear_count),
        .locked_o      (locked),
        .err_pulse_o   (err_pulse),
        .err_count_o   (err_count),
        .state_o       (state)
    );

    always #5 clk = ~clk;

    // Position following the 4-bit window in the reference table, or -1.
    function automatic int find_phase(input int win);
        for (int k = 0; k < 15; k++) begin
            int w;
            w = (ref_bits[k] << 3) | (ref_bits[(k+1)%15] << 2) |
                (ref_bits[(k+2)%15] << 1) | ref_bits[(k+3)%15];
            if (w == win) return (k + 4) % 15;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_win = 0; m_n = 0; m_match = 0;
        m_loss = 0; m_pos = 0; m_pulse = 0; m_cnt = 0;
    endtask

    task automatic model_update(input logic en, input logic d, input logic clr);
        int  exp_bit;
        int  ph;
        bit  err;
        err     = 1'b0;
        m_pulse = 0;
        if (en) begin
            case (m_state)
                0: begin
                    m_win = ((m_win << 1) | int'(d)) & 15;
                    m_n++;
                    if (m_n == 4) begin
                        m_n = 0;
                        ph  = find_phase(m_win);
                        if (ph >= 0) begin
                            m_pos = ph; m_state = 1; m_match = 0;
                        end
                    end
                end
                1: begin
                    exp_bit = ref_bits[m_pos];
                    m_pos   = (m_pos + 1) % 15;
                    if (int'(d) == exp_bit) begin
                        m_match++;
                        if (m_match == LOCK_T) begin
                            m_state = 2; m_loss = 0; m_match = 0;
                        end
                    end else begin
                        m_state = 0; m_n = 0; m_match = 0;
                    end
                end
                default: begin
                    exp_bit = ref_bits[m_pos];
                    m_pos   = (m_pos + 1) % 15;
                    if (int'(d) != exp_bit) begin
                        err = 1'b1; m_pulse = 1; m_loss++;
                        if (m_loss == LOSS_T) begin
                            m_state = 0; m_n = 0; m_loss = 0;
                        end
                    end else begin
                        m_loss = 0;
                    end
                end
            endcase
        end
        if (clr) m_cnt = 0;
        else if (err && m_cnt < 255) m_cnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},     32'(state),     32'(m_state));
        chk({tag, ".locked"},    32'(locked),    32'(m_state == 2));
        chk({tag, ".err_pulse"}, 32'(err_pulse), 32'(m_pulse));
        chk({tag, ".err_count"}, 32'(err_count), 32'(m_cnt));
    endtask

    task automatic step_raw(input logic en, input logic d, input logic clr, input string tag);
        enable      = en;
        data_in     = d;
        clear_count = clr;
        @(posedge clk);
        #1;
        model_update(en, d, clr);
        check_all(tag);
    endtask

    // Send the next generator bit (optionally inverted) or an idle cycle.
    task automatic step(input logic en, input logic err, input logic clr, input string tag);
        logic d;
        if (en) begin
            d = (ref_bits[g] != 0) ^ err;
            g = (g + 1) % 15;
        end else begin
            d = 1'($urandom_range(1, 0));
        end
        step_raw(en, d, clr, tag);
    endtask

    task automatic do_reset(input string tag);
        reset       = 1'b1;
        enable      = 1'b0;
        clear_count = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        reset = 1'b0;
        g     = 0;
    endtask

    initial begin
        int npulse;
        reset = 1'b1; enable = 1'b0; data_in = 1'b0; clear_count = 1'b0;
        model_reset();

        // Reset state and acquisition
        do_reset("rst0");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, "seed");
        chk("seed_to_verify", 32'(state), 32'd1);
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, "verify");
        chk("not_locked_bit11", 32'(locked), 32'd0);
        step(1'b1, 1'b0, 1'b0, "bit12");
        chk("locked_bit12", 32'(locked), 32'd1);

        // Single error
        step(1'b1, 1'b1, 1'b0, "single_err");
        chk("single_pulse", 32'(err_pulse), 32'd1);
        chk("single_count", 32'(err_count), 32'd1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, "after_single");
        chk("single_still_locked", 32'(locked), 32'd1);

        // Loss of lock and relock
        npulse = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0, "loss");
            npulse += int'(err_pulse);
        end
        chk("loss_pulses", 32'(npulse), 32'd3);
        chk("loss_count", 32'(err_count), 32'd4);
        chk("loss_unlocked", 32'(locked), 32'd0);
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 1'b0, "relock");
        chk("relock_bit11", 32'(locked), 32'd0);
        step(1'b1, 1'b0, 1'b0, "relock12");
        chk("relock_bit12", 32'(locked), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(3, 0) != 0), 1'($urandom_range(11, 0) == 0),
                 1'($urandom_range(39, 0) == 0), "rand");
        end

        // Lock-up seed
        do_reset("rst1");
        for (int i = 0; i < 8; i++) step_raw(1'b1, 1'b1, 1'b0, "ones");
        chk("lockup_seed_state", 32'(state), 32'd0);
        chk("lockup_unlocked", 32'(locked), 32'd0);
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, "after_ones");
        chk("lockup_then_lock", 32'(locked), 32'd1);

        // Gapped acquisition
        do_reset("rst2");
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b0, "gap_v");
            step(1'b0, 1'b0, 1'b0, "gap_i");
        end
        chk("gap_lock", 32'(locked), 32'd1);

        // Saturation: 100 bursts of 3 errors with relock in between
        for (int b = 0; b < 100; b++) begin
            for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, "sat_err");
            for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, "sat_relock");
        end
        chk("sat_count", 32'(err_count), 32'd255);
        chk("sat_locked", 32'(locked), 32'd1);

        // Clear concurrent with an error
        step(1'b1, 1'b1, 1'b1, "clr_err");
        chk("clr_wins", 32'(err_count), 32'd0);
        chk("clr_pulse", 32'(err_pulse), 32'd1);
        step(1'b1, 1'b0, 1'b0, "clr_after");

        // Build err_count = 5 while locked, then reset asynchronously
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 1'b0, "five_err");
            step(1'b1, 1'b0, 1'b0, "five_ok");
        end
        chk("five_count", 32'(err_count), 32'd5);
        chk("five_locked", 32'(locked), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_locked", 32'(locked), 32'd0);
        chk("async_count", 32'(err_count), 32'd0);
        chk("async_state", 32'(state), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        g     = 0;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0, "post_rst");
        chk("post_rst_lock", 32'(locked), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_prbs4_checker
`default_nettype wire
